// File: rtl/cla_chunk_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_chunk_add_seq_if
// Brief    : Operand/result handshakes plus the chunk-adder drive/return bus.
// Revision : 1.0
// ============================================================================
interface cla_chunk_add_seq_if #(
    parameter int DATA_WID   = 16,
    parameter int NUM_CHUNKS = 4
);
    localparam int W = DATA_WID * NUM_CHUNKS;

    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_a;
    logic [W-1:0]        in_b;
    logic                in_cin;

    logic [DATA_WID-1:0] add_in1;
    logic [DATA_WID-1:0] add_in2;
    logic                add_cin;
    logic [DATA_WID-1:0] add_sum;
    logic                add_cout;

    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_sum;
    logic                out_cout;
    logic                out_ovf;

    // Controller view
    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_in1, add_in2, add_cin, out_valid, out_sum, out_cout, out_ovf
    );

    // Producer / consumer / adder view
    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_in1, add_in2, add_cin, out_valid, out_sum, out_cout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_chunk_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_chunk_add_seq
// Brief    : Sequences a wide add through an external DATA_WID-bit CLA adder.
// Revision : 1.0
// ============================================================================
module cla_chunk_add_seq #(
    parameter int DATA_WID   = 16,
    parameter int NUM_CHUNKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_chunk_add_seq_if.slave bus
);
    localparam int W     = DATA_WID * NUM_CHUNKS;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               cin_q, cin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DATA_WID-1:0] a_chunk;
    logic [DATA_WID-1:0] b_chunk;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_chunk = a_q[k*DATA_WID +: DATA_WID];
                b_chunk = b_q[k*DATA_WID +: DATA_WID];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_in1   = '0;
        bus.add_in2   = '0;
        bus.add_cin   = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    cin_d   = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.add_in1 = a_chunk;
                bus.add_in2 = b_chunk;
                bus.add_cin = (idx_q == '0) ? cin_q : carry_q;
                for (int k = 0; k < NUM_CHUNKS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*DATA_WID +: DATA_WID] = bus.add_sum;
                    end
                end
                carry_d = bus.add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = bus.add_cout;
                    // carry into the MSB recovered from the top sum bit and operand MSBs
                    ovf_d   = bus.add_cout ^ (bus.add_sum[DATA_WID-1] ^ a_q[W-1] ^ b_q[W-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;
    assign bus.out_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_chunk_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_chunk_add_seq
// Brief    : Directed and randomized checks of the chunked wide-add sequencer.
// Revision : 1.0
// ============================================================================
module tb_cla_chunk_add_seq;
    localparam int DATA_WID   = 16;
    localparam int NUM_CHUNKS = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cla_chunk_add_seq_if #(.DATA_WID(DATA_WID), .NUM_CHUNKS(NUM_CHUNKS)) bus ();

    cla_chunk_add_seq #(.DATA_WID(DATA_WID), .NUM_CHUNKS(NUM_CHUNKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the external 16-bit adder
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_in1} + {1'b0, bus.add_in2} + 17'(bus.add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic [63:0] es, input logic ec,
                          input logic eo, input int hold);
        int n;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = ci;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check({tag, "_accept_timeout"}, bus.in_ready, 65'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_cin   = ~ci;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check({tag, "_valid_timeout"}, bus.out_valid, 65'd1);
        for (int i = 0; i < hold; i++) tick();
        check({tag, "_sum"},  bus.out_sum,  es);
        check({tag, "_cout"}, bus.out_cout, ec);
        check({tag, "_ovf"},  bus.out_ovf,  eo);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] ra, rb, rs;
        logic        rc, rco, rov;
        logic        seen;

        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        check("rst_in_ready",  bus.in_ready,  65'd1);
        check("rst_out_valid", bus.out_valid, 65'd0);
        check("rst_out_sum",   bus.out_sum,   65'd0);
        check("rst_out_cout",  bus.out_cout,  65'd0);
        check("rst_out_ovf",   bus.out_ovf,   65'd0);
        check("rst_add_in1",   bus.add_in1,   65'd0);
        check("rst_add_cin",   bus.add_cin,   65'd0);
        rst_n = 1'b1;
        tick();

        // Carry ripple across every chunk, with per-cycle latency and drive checks
        bus.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_b     = 64'h0;
        bus.in_cin   = 1'b1;
        bus.in_valid = 1'b1;
        check("idle_add_in1", bus.add_in1, 65'd0);
        check("idle_add_in2", bus.add_in2, 65'd0);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 64'h0;
        bus.in_cin   = 1'b0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            check("rip_in_ready",  bus.in_ready,  65'd0);
            check("rip_out_valid", bus.out_valid, 65'd0);
            check("rip_add_cin",   bus.add_cin,   65'd1);
            check("rip_add_in1",   bus.add_in1,   65'h0FFFF);
            tick();
        end
        check("rip_valid_at_lat", bus.out_valid, 65'd1);
        check("rip_done_ready",   bus.in_ready,  65'd0);
        check("rip_sum",          bus.out_sum,   65'd0);
        check("rip_cout",         bus.out_cout,  65'd1);
        check("rip_ovf",          bus.out_ovf,   65'd0);
        check("rip_post_add_in1", bus.add_in1,   65'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("rip_back_idle", bus.in_ready, 65'd1);

        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);

        // Backpressure: result must hold while DONE ignores new operands
        bus.in_a     = 64'h0123_4567_89AB_CDEF;
        bus.in_b     = 64'h1111_1111_1111_1111;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (NUM_CHUNKS) tick();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = i[0];
            bus.in_a     = 64'hDEAD_BEEF_DEAD_BEEF;
            check("bp_valid", bus.out_valid, 65'd1);
            check("bp_sum",   bus.out_sum,   65'h1234_5678_9ABC_DF00);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle_ready", bus.in_ready,  65'd1);
        check("bp_idle_valid", bus.out_valid, 65'd0);
        check("bp_sum_kept",   bus.out_sum,   65'h1234_5678_9ABC_DF00);

        // Asynchronous reset during chunk 2
        bus.in_a     = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.in_b     = 64'h5555_5555_5555_5555;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("mid_add_in1", bus.add_in1, 65'h0AAAA);
        rst_n = 1'b0;
        #1;
        check("mr_in_ready",  bus.in_ready,  65'd1);
        check("mr_out_valid", bus.out_valid, 65'd0);
        check("mr_out_sum",   bus.out_sum,   65'd0);
        check("mr_add_in1",   bus.add_in1,   65'd0);
        check("mr_add_in2",   bus.add_in2,   65'd0);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        check("mr_no_valid", seen, 65'd0);
        run_op("post_rst", 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0, 1);

        // Randomized operands with idle and backpressure gaps
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'(($urandom() >> 3) & 1);
            if (i % 4 == 0) ra[47:16] = 32'hFFFF_FFFF;
            if (i % 8 == 1) rb = ~ra;
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + 65'(rc);
            rov = (ra[63] == rb[63]) && (rs[63] != ra[63]);
            repeat ($urandom_range(0, 3)) tick();
            run_op("rnd", ra, rb, rc, rs, rco, rov, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cla_chunk_add_seq.md
Name: cla_chunk_add_seq

Overview:
- Multi-cycle wide adder controller that sits directly around the 16-bit carry look-ahead adder, acting as both its upstream and downstream stage.
- Accepts two wide operands over a valid/ready handshake and feeds the adder one DATA_WID-bit chunk per cycle, LSB chunk first, chaining carry between chunks.
- Collects the chunk sums and presents the full-width sum, carry-out and signed-overflow flag on a valid/ready output handshake.
- The adder instance is external; this block drives its inputs and samples its combinational outputs in the same cycle.

Parameters:
- DATA_WID, 16, chunk width; must equal the connected adder's width.
- NUM_CHUNKS, 4, chunks per operand; total width W = DATA_WID*NUM_CHUNKS (64 by default); legal range 2..16.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into bit 0.
- add_in1  output  DATA_WID  to adder in1.
- add_in2  output  DATA_WID  to adder in2.
- add_cin  output  1  to adder carry_in.
- add_sum  input  DATA_WID  from adder sum (combinational).
- add_cout  input  1  from adder carry_out (combinational).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  A+B+cin modulo 2^W.
- out_cout  output  1  unsigned carry out of bit W-1.
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state:
  - FSM in IDLE; in_ready=1; out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - Operand regs, chunk index and carry reg cleared.
  - add_in1/add_in2/add_cin driven 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b, in_cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Adder drive: add_in1=A[idx*DATA_WID +: DATA_WID]; add_in2=same slice of B.
  - add_cin = latched cin when idx==0, else the carry reg.
  - Each cycle: result[idx chunk]<=add_sum; carry reg<=add_cout; idx<=idx+1.
  - On the cycle idx==NUM_CHUNKS-1, additionally:
    - out_cout<=add_cout.
    - out_ovf<=add_cout ^ (add_sum[MSB]^A[W-1]^B[W-1]), i.e. the carry into the MSB XOR the carry out.
    - Go to DONE.
  - RUN lasts exactly NUM_CHUNKS cycles.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf held stable while out_valid&!out_ready.
  - On out_ready: go to IDLE.
  - in_ready stays 0 in DONE; single result buffer, no overlap of accept with hold.
- Latency: if accept occurs at edge t, out_valid rises after edge t+NUM_CHUNKS. Throughput is one operation per NUM_CHUNKS+2 cycles at best.
- add_in1/add_in2/add_cin are forced to 0 outside RUN, so idle toggling on the adder is zero.
- in_a/in_b/in_cin changes after acceptance have no effect on the result.
- out_sum keeps its last value after leaving DONE until the next result overwrites it.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to reset state; the partial result is discarded.
  - No out_valid after deassertion without a new accept.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored (not latched).
- Arithmetic: out_sum = (A+B+cin) mod 2^W; {out_cout,out_sum} = A+B+cin exactly.

Test Plan:
- Carry ripple across all chunks: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=0, out_cout=1, out_ovf=0. Expected add_cin sequence: 1,1,1,1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
- Latency and idle drive: accept at cycle 10 -> out_valid first high after edge 14, in_ready=0 during cycles 11-15. add_in1=add_in2=0 before and after RUN.
- Backpressure: out_ready=0 for 7 cycles in DONE -> out_valid and out_sum stable throughout; in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 during chunk 2 -> all outputs go to reset values immediately; after release, no out_valid until a new accept. A new op 5+7 then yields out_sum=12.
- Random: 1000 operand/cin triples with random in_valid/out_ready gaps -> every result equals the golden W+1-bit sum. out_ovf matches the signed-overflow model.
